wb_bypass_pipe: RTL and testbench

- Parametrised successor to the single-cycle write-address / write-data select muxes.
- Carries each issued register write (address, data-source select, data) down a STAGES-deep in-flight pipeline and selects the final write-back data per source (ALU / memory / PC+4).
- Forwards in-flight results to NREAD operand read ports; raises a load-use stall when a needed value is not yet produced.
- Sits between decode/issue and the register file of the pipelined CPU.

---
 rtl/wb_bypass_pipe.sv | 137 +++++++++++++
 tb/tb_wb_bypass_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bypass_pipe.sv
// In-flight register-write pipeline with per-source write-back select, operand
// forwarding to NREAD read ports and load-use stall detection.
module wb_bypass_pipe #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int STAGES = 3,
   parameter int NREAD  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     iss_valid,
   input  logic [ADDR_W-1:0]        iss_wa,
   input  logic [1:0]               iss_wsel,
   input  logic [DATA_W-1:0]        iss_pc4,
   input  logic [DATA_W-1:0]        alu_out,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic [NREAD*ADDR_W-1:0]  rd_addr,
   input  logic [NREAD*DATA_W-1:0]  rf_data,
   output logic [NREAD*DATA_W-1:0]  opnd,
   output logic                     stall,
   output logic                     wb_we,
   output logic [ADDR_W-1:0]        wb_wa,
   output logic [DATA_W-1:0]        wb_wd
);

   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_PC4 = 2'd2;

   logic              valid_reg [STAGES];
   logic              ready_reg [STAGES];
   logic [ADDR_W-1:0] wa_reg    [STAGES];
   logic [DATA_W-1:0] data_reg  [STAGES];
   // Source select is only consulted while the entry is in EX or MEM.
   logic [1:0]        wsel0_reg;
   logic [1:0]        wsel1_reg;

   logic              capture;
   logic [NREAD-1:0]  miss_vec;

   function automatic logic is_alu(input logic [1:0] sel);
      return (sel != SEL_MEM) && (sel != SEL_PC4);
   endfunction

   assign capture = iss_valid && !stall && (iss_wa != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_reg[k] <= 1'b0;
            ready_reg[k] <= 1'b0;
            wa_reg[k]    <= '0;
            data_reg[k]  <= '0;
         end
         wsel0_reg <= '0;
         wsel1_reg <= '0;
         wb_we     <= 1'b0;
         wb_wa     <= '0;
         wb_wd     <= '0;
      end else begin
         valid_reg[0] <= capture;
         ready_reg[0] <= capture && (iss_wsel == SEL_PC4);
         wa_reg[0]    <= iss_wa;
         wsel0_reg    <= iss_wsel;
         data_reg[0]  <= iss_pc4;

         valid_reg[1] <= valid_reg[0];
         wa_reg[1]    <= wa_reg[0];
         wsel1_reg    <= wsel0_reg;
         data_reg[1]  <= is_alu(wsel0_reg) ? alu_out : data_reg[0];
         ready_reg[1] <= ready_reg[0] || (valid_reg[0] && is_alu(wsel0_reg));

         for (int k = 2; k < STAGES; k++) begin
            valid_reg[k] <= valid_reg[k-1];
            wa_reg[k]    <= wa_reg[k-1];
            if (k == 2) begin
               data_reg[k]  <= (wsel1_reg == SEL_MEM) ? mem_rdata : data_reg[k-1];
               ready_reg[k] <= ready_reg[k-1] || (valid_reg[k-1] && (wsel1_reg == SEL_MEM));
            end else begin
               data_reg[k]  <= data_reg[k-1];
               ready_reg[k] <= ready_reg[k-1];
            end
         end

         wb_we <= valid_reg[STAGES-1];
         wb_wa <= wa_reg[STAGES-1];
         wb_wd <= data_reg[STAGES-1];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NREAD; gi++) begin : g_port
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] fwd;
         logic              miss;

         assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

         // Scan oldest to youngest so the youngest matching writer lands last.
         always_comb begin
            fwd  = rf_data[gi*DATA_W +: DATA_W];
            miss = 1'b0;
            if (wb_we && (wb_wa == ra)) begin
               fwd = wb_wd;
            end
            for (int k = STAGES - 1; k >= 0; k--) begin
               if (valid_reg[k] && (wa_reg[k] == ra)) begin
                  miss = 1'b0;
                  if (ready_reg[k]) begin
                     fwd = data_reg[k];
                  end else if (k == 0) begin
                     if (wsel0_reg == SEL_MEM) begin
                        miss = 1'b1;
                     end else begin
                        fwd = alu_out;
                     end
                  end else if (k == 1) begin
                     fwd = mem_rdata;
                  end else begin
                     miss = 1'b1;
                  end
               end
            end
            if (ra == '0) begin
               fwd  = '0;
               miss = 1'b0;
            end
         end

         assign opnd[gi*DATA_W +: DATA_W] = fwd;
         assign miss_vec[gi]              = miss;
      end
   endgenerate

   assign stall = |miss_vec;

endmodule

// File: tb/tb_wb_bypass_pipe.sv
// Directed bench for wb_bypass_pipe: latency, forwarding, load-use stall,
// WAW priority, r0 handling and asynchronous reset mid-stream.
module tb_wb_bypass_pipe;

   logic        clk;
   logic        reset;
   logic        iss_valid;
   logic [4:0]  iss_wa;
   logic [1:0]  iss_wsel;
   logic [31:0] iss_pc4;
   logic [31:0] alu_out;
   logic [31:0] mem_rdata;
   logic [9:0]  rd_addr;
   logic [63:0] rf_data;
   logic [63:0] opnd;
   logic        stall;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wd;

   int total = 0;
   int bad   = 0;

   wb_bypass_pipe #(.DATA_W(32), .ADDR_W(5), .STAGES(3), .NREAD(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .iss_valid (iss_valid),
      .iss_wa    (iss_wa),
      .iss_wsel  (iss_wsel),
      .iss_pc4   (iss_pc4),
      .alu_out   (alu_out),
      .mem_rdata (mem_rdata),
      .rd_addr   (rd_addr),
      .rf_data   (rf_data),
      .opnd      (opnd),
      .stall     (stall),
      .wb_we     (wb_we),
      .wb_wa     (wb_wa),
      .wb_wd     (wb_wd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] wa, input logic [1:0] sel, input logic [31:0] pc4);
      iss_valid = 1'b1;
      iss_wa    = wa;
      iss_wsel  = sel;
      iss_pc4   = pc4;
   endtask

   task automatic idle();
      iss_valid = 1'b0;
      iss_wa    = 5'd0;
      iss_wsel  = 2'd0;
      iss_pc4   = 32'h0;
   endtask

   task automatic set_rd(input int p, input logic [4:0] a);
      rd_addr[p*5 +: 5] = a;
   endtask

   function automatic logic [31:0] op(input int p);
      return opnd[p*32 +: 32];
   endfunction

   initial begin
      // Reset with every input active
      reset     = 1'b1;
      issue(5'd3, 2'd0, 32'h1234);
      alu_out   = 32'h77;
      mem_rdata = 32'h88;
      rd_addr   = {5'd2, 5'd1};
      rf_data   = {32'h2222, 32'h1111};
      repeat (2) tick();
      #2;
      chk("rst_we",    wb_we, 0);
      chk("rst_wa",    wb_wa, 0);
      chk("rst_wd",    wb_wd, 0);
      chk("rst_stall", stall, 0);
      chk("rst_op0",   op(0), 32'h1111);
      chk("rst_op1",   op(1), 32'h2222);
      reset = 1'b0;
      idle();
      rd_addr = '0;
      tick();

      // Single ALU write: write-back appears after three further edges
      issue(5'd3, 2'd0, 32'h0);
      tick();
      idle();
      alu_out = 32'h11;
      #2 chk("lat_c1_we", wb_we, 0);
      tick();
      #2 chk("lat_c2_we", wb_we, 0);
      tick();
      set_rd(0, 5'd3);
      #2;
      chk("lat_c3_we", wb_we, 0);
      chk("lat_s2_fwd", op(0), 32'h11);
      tick();
      #2;
      chk("lat_wb_we", wb_we, 1);
      chk("lat_wb_wa", wb_wa, 3);
      chk("lat_wb_wd", wb_wd, 32'h11);
      set_rd(0, 5'd0);
      tick();

      // ALU -> ALU back-to-back
      issue(5'd5, 2'd0, 32'h0);
      tick();
      idle();
      set_rd(0, 5'd5);
      alu_out = 32'hAB;
      #2;
      chk("alu_fwd_op0", op(0), 32'hAB);
      chk("alu_fwd_stall", stall, 0);
      set_rd(0, 5'd0);
      tick();

      // Load-use stall; the issue presented while stalled must be dropped
      issue(5'd7, 2'd1, 32'h0);
      tick();
      issue(5'd9, 2'd0, 32'h0);
      set_rd(1, 5'd7);
      #2 chk("lu_stall", stall, 1);
      tick();
      idle();
      mem_rdata = 32'hCAFE;
      set_rd(0, 5'd9);
      #2;
      chk("lu_stall_clr", stall, 0);
      chk("lu_op1", op(1), 32'hCAFE);
      chk("lu_drop_op0", op(0), 32'h1111);
      chk("lu_wb5_we", wb_we, 1);
      chk("lu_wb5_wa", wb_wa, 5);
      chk("lu_wb5_wd", wb_wd, 32'hAB);
      tick();
      mem_rdata = 32'h0;
      #2 chk("lu_s2_op1", op(1), 32'hCAFE);
      tick();
      #2;
      chk("lu_wb_wa", wb_wa, 7);
      chk("lu_wb_wd", wb_wd, 32'hCAFE);
      rd_addr = '0;
      repeat (3) tick();
      #2 chk("drop_no_wb", wb_we, 0);

      // WAW: younger ALU write to r4 beats older PC4 write
      issue(5'd4, 2'd2, 32'h3004);
      tick();
      issue(5'd4, 2'd0, 32'h0);
      tick();
      idle();
      alu_out = 32'h55;
      set_rd(0, 5'd4);
      #2 chk("waw_s0", op(0), 32'h55);
      tick();
      alu_out = 32'h0;
      #2 chk("waw_s1", op(0), 32'h55);
      tick();
      #2;
      chk("waw_s2", op(0), 32'h55);
      chk("waw_wb_old", wb_wd, 32'h3004);
      tick();
      #2 chk("waw_wb_new", op(0), 32'h55);
      rd_addr = '0;
      repeat (2) tick();

      // r0 never enters the pipe
      issue(5'd0, 2'd0, 32'h0);
      tick();
      idle();
      alu_out = 32'h66;
      for (int i = 0; i < 5; i++) begin
         #2 chk($sformatf("r0_no_wb_%0d", i), wb_we, 0);
         tick();
      end

      // Write-back output bypass, and r0 reads as zero
      issue(5'd10, 2'd0, 32'h0);
      tick();
      idle();
      alu_out = 32'h99;
      repeat (3) tick();
      rf_data = {32'hDEAD, 32'h0};
      set_rd(0, 5'd10);
      set_rd(1, 5'd0);
      #2;
      chk("wbbyp_we", wb_we, 1);
      chk("wbbyp_op0", op(0), 32'h99);
      chk("r0_op1", op(1), 32'h0);
      rd_addr = '0;
      rf_data = {32'h2222, 32'h1111};
      tick();

      // Asynchronous reset with entries in flight
      alu_out = 32'hA1;
      issue(5'd1, 2'd0, 32'h0);
      tick();
      issue(5'd2, 2'd0, 32'h0);
      tick();
      issue(5'd3, 2'd0, 32'h0);
      tick();
      issue(5'd6, 2'd1, 32'h0);
      tick();
      idle();
      set_rd(0, 5'd6);
      #2;
      chk("ar_pre_stall", stall, 1);
      chk("ar_pre_we", wb_we, 1);
      chk("ar_pre_wa", wb_wa, 1);
      chk("ar_pre_wd", wb_wd, 32'hA1);
      reset = 1'b1;
      #1;
      chk("ar_we", wb_we, 0);
      chk("ar_wa", wb_wa, 0);
      chk("ar_wd", wb_wd, 0);
      chk("ar_stall", stall, 0);
      chk("ar_op0", op(0), 32'h1111);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #2 chk($sformatf("ar_no_wb_%0d", i), wb_we, 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
